// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   PC_STEP_DEFAULT  : byte increment between sequential fetches
//   NOP_INSTR        : word shown on if_instr while nothing has been fetched
//   fetch_word_t     : instruction word paired with its byte address
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order buffer between instruction_mem and decode: an output
// register (oldest word, shown to decode) backed by a one-word skid.
//   clk, rst           : clock, async active-high reset
//   flush              : drop both entries; any push this cycle is ignored
//   push, push_word    : returning instruction word to enqueue
//   pop                : consumer ready; takes the output word when valid
//   out_valid/out_word : head of the buffer
//   skid_valid         : second entry occupied (buffer full)
// The upstream issue rule never pushes into a full buffer that is not popped.
module fetch_skid_buf
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  fetch_word_t push_word,
  input  logic        pop,
  output logic        out_valid,
  output fetch_word_t out_word,
  output logic        skid_valid
);

  fetch_word_t skid_word;
  logic        take;

  assign take = out_valid && pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_word   <= '{pc: RESET_PC, instr: NOP_INSTR};
      skid_valid <= 1'b0;
      skid_word  <= '{pc: RESET_PC, instr: NOP_INSTR};
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // Full: only moves when the head is consumed; the new word backfills skid.
      if (take) begin
        out_word   <= skid_word;
        skid_valid <= push;
        if (push) skid_word <= push_word;
      end
    end else if (!out_valid || take) begin
      out_valid <= push;
      if (push) out_word <= push_word;
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_word  <= push_word;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to instruction_mem,
// pairs each returning word with its PC and hands it to decode over
// valid/ready. Execute-stage redirects flush the stage.
//   clk, rst                  : clock, async active-high reset
//   imem_rd, imem_addr        : read request to instruction_mem
//   imem_instr                : read data, valid the cycle after imem_rd
//   redirect_valid/_pc        : PC redirect from execute (highest priority)
//   if_valid/if_pc/if_instr   : fetched instruction to decode
//   id_ready                  : decode accepts this cycle
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  localparam logic [31:0] RST_PC = RESET_PC & ~32'h3;

  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_pc;
  logic        out_valid;
  logic        skid_valid;
  fetch_word_t out_word;
  logic        issue;

  // Request is held low while rst is high; once rst drops, the first request
  // is up in time to be sampled on the very next edge.
  always_comb begin
    issue     = 1'b0;
    imem_addr = pc;
    if (!rst) begin
      if (redirect_valid) begin
        issue     = 1'b1;
        imem_addr = word_align(redirect_pc);
      end else begin
        // Stop when the skid is full, or when the in-flight word is about to
        // land in the skid (head stalled with a response pending).
        issue = !skid_valid && !(out_valid && pend && !id_ready);
      end
    end
  end

  assign imem_rd = issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RST_PC;
      pend    <= 1'b0;
      pend_pc <= RST_PC;
    end else begin
      pend <= issue;
      if (issue) begin
        pend_pc <= imem_addr;
        pc      <= imem_addr + PC_STEP;
      end
    end
  end

  // A redirect flushes the buffer and the response of the previous request.
  fetch_skid_buf #(.RESET_PC(RST_PC)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (pend),
    .push_word ('{pc: pend_pc, instr: imem_instr}),
    .pop       (id_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .skid_valid(skid_valid)
  );

  assign if_valid = out_valid;
  assign if_pc    = out_word.pc;
  assign if_instr = out_word.instr;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of instruction_mem.
- Owns the PC and drives instruction_mem's rd/instr_addr request lines.
- Instruction words return one cycle after a request. The block pairs each word with its PC and presents it to decode through a valid/ready handshake.
- A 1-entry skid buffer absorbs the in-flight word when decode stalls. Branch/jump redirects from execute flush the stage.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_rd  out  1  fetch request to instruction_mem (rd).
- imem_addr  out  32  byte address to instruction_mem (instr_addr); bits [1:0] always 00.
- imem_instr  in  32  instruction word from instruction_mem; valid the cycle after imem_rd=1.
- redirect_valid  in  1  execute-stage PC redirect.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 00).
- if_valid  out  1  fetched instruction available to decode.
- if_pc  out  32  byte address of if_instr.
- if_instr  out  32  instruction word.
- id_ready  in  1  decode accepts if_* this cycle.

Behaviour:
- State:
  - pc: next sequential fetch address.
  - pend, pend_pc: a request was issued last cycle.
  - out_valid/out_pc/out_instr: output register.
  - skid_valid/skid_pc/skid_instr: skid buffer.
- Reset (async, while rst=1):
  - pc=RESET_PC; pend=0; out_valid=0; skid_valid=0.
  - if_pc=RESET_PC; if_instr=32'h0000_0013 (NOP); imem_rd=0.
- Outputs:
  - if_* driven from the output register.
  - imem_rd/imem_addr are combinational from registered state plus redirect inputs. instruction_mem samples them at the next edge.
- Issue rule (no redirect):
  - imem_rd = !skid_valid && !(out_valid && pend && !id_ready).
  - imem_addr = pc.
  - On issue: pc <= pc+PC_STEP, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); pend <= 1; pend_pc <= pc.
  - Otherwise pend <= 0.
- Response capture when pend=1:
  - Output register empty or being consumed this cycle, and skid empty: word goes to output register.
  - Output full and not consumed: word goes to skid.
- Draining: when output is consumed and skid_valid=1, skid moves to the output register and skid_valid <= 0. The pending word, if any, goes to skid that same cycle.
- Ordering: output holds the oldest word, skid the next, pending the youngest. Ordering is strictly in-order and never more than 3 words in flight. The issue rule guarantees no overflow.
- Latency and throughput:
  - First if_valid rises 2 cycles after rst deasserts (issue cycle, then response captured).
  - Steady state with id_ready=1 is 1 instruction per cycle.
- Handshake:
  - if_valid/if_pc/if_instr are held stable while if_valid=1 and id_ready=0.
  - A transfer occurs on if_valid && id_ready.
- Redirect (highest priority):
  - In the redirect cycle: imem_rd=1 and imem_addr={redirect_pc[31:2],2'b00}, regardless of stall state.
  - Next edge: out_valid <= 0 and skid_valid <= 0. The pending response is discarded and not captured.
  - Next edge: pend <= 1 with pend_pc = target; pc <= target+PC_STEP.
  - id_ready in the redirect cycle is ignored; any handshake in that cycle is void.
  - Back-to-back redirects: the latest one wins.
- Reset mid-operation clears everything immediately. No request is asserted until the first edge after rst deasserts.

Decomposition:
- Shared defines.vh gains `RESET_PC_DEFAULT`, `NOP_INSTR` (32'h00000013) and `PC_STEP`.
- One natural sub-module, fetch_skid_buf: the 2-entry in-order buffer (output register plus skid) with flush, push and pop, and occupancy outputs used by the issue rule.

Test Plan:
- Reset release, id_ready=1, imem preloaded with words i -> imem_addr 0,4,8,… each cycle. First if_valid 2 cycles after reset with if_pc=0, if_instr=imem[0]; then one word per cycle with if_pc incrementing by 4.
- id_ready low for 5 cycles mid-stream at if_pc=0x10 -> if_* held at 0x10; skid holds 0x14; imem_rd=0. On release: 0x10, 0x14, 0x18 delivered consecutively, no duplicates or drops.
- redirect_valid with redirect_pc=0x200 while stalled with skid full -> same-cycle imem_addr=0x200. Next cycle if_valid=0. Following cycle if_pc=0x200, then 0x204; no stale 0x1x words appear.
- redirect_pc=0x203 -> imem_addr=0x200, if_pc=0x200.
- RESET_PC=0xFFFF_FFF8, run 3 fetches -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst asserted mid-stream with skid full -> if_valid=0 and imem_rd=0 immediately (asynchronous). After release, refetch starts at RESET_PC.
